block_emitter: RTL and testbench

Generates the ASCII keyword stream that the block-nesting checker consumes. Upstream logic issues abstract begin/end tokens over a valid/ready command port. The block serialises each token into its lowercase keyword followed by one space, one character per output transfer. It tracks nesting depth so the producer knows whether the emitted stream is balanced.

---
 rtl/block_emitter_if.sv | 21 ++
 rtl/block_emitter.sv | 86 ++++++++
 tb/tb_block_emitter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/block_emitter_if.sv
// block_emitter_if: command port, character stream and nesting status of block_emitter
interface block_emitter_if #(parameter int DEPTH_W = 4);
  logic               cmd_valid;
  logic               cmd_end;
  logic               cmd_ready;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_char;
  logic [DEPTH_W-1:0] depth;
  logic               balanced;
  logic               err_underflow;
  logic               err_overflow;
  modport master (
    output cmd_valid, cmd_end, out_ready,
    input  cmd_ready, out_valid, out_char, depth, balanced, err_underflow, err_overflow
  );
  modport slave (
    input  cmd_valid, cmd_end, out_ready,
    output cmd_ready, out_valid, out_char, depth, balanced, err_underflow, err_overflow
  );
endinterface

// File: rtl/block_emitter.sv
// block_emitter: serialises begin/end tokens as "begin "/"end ", one character per transfer, tracking depth.
// BLOCK_EMITTER_GUARD_EN: drop underflowing/overflowing commands instead of emitting them.
module block_emitter #(
  parameter int MAX_DEPTH = 15,
  parameter int DEPTH_W   = 4
) (
  input logic           clk,
  input logic           reset,
  block_emitter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WORD, SEP} state_t;
  state_t             state_q;
  logic               end_q;
  logic [2:0]         idx_q;
  logic               out_valid_q;
  logic [7:0]         out_char_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               uf_q;
  logic               of_q;
  logic               accept;
  logic               illegal;
  logic               drop;
  logic               last;
  logic [2:0]         idx_d;
  logic [DEPTH_W-1:0] depth_d;
  function automatic logic [7:0] kw(input logic e, input logic [2:0] i);
    kw = e ? (i == 3'd0 ? "e" : i == 3'd1 ? "n" : "d")
           : (i == 3'd0 ? "b" : i == 3'd1 ? "e" : i == 3'd2 ? "g" : i == 3'd3 ? "i" : "n");
  endfunction
  assign accept  = bus.cmd_valid && state_q == IDLE;
  assign illegal = bus.cmd_end ? depth_q == '0 : depth_q == DEPTH_W'(MAX_DEPTH);
`ifdef BLOCK_EMITTER_GUARD_EN
  assign drop = illegal;
`else
  assign drop = 1'b0;
`endif
  assign idx_d   = idx_q + 3'd1;
  assign last    = idx_q == (end_q ? 3'd2 : 3'd4);
  // depth clamps at both ends; the matching sticky flag records the attempt
  assign depth_d = illegal ? depth_q : bus.cmd_end ? depth_q - DEPTH_W'(1) : depth_q + DEPTH_W'(1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      end_q       <= 1'b0;
      idx_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      depth_q     <= '0;
      uf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          depth_q <= depth_d;
          uf_q    <= uf_q | (illegal & bus.cmd_end);
          of_q    <= of_q | (illegal & ~bus.cmd_end);
          if (!drop) begin
            state_q     <= WORD;
            end_q       <= bus.cmd_end;
            idx_q       <= 3'd0;
            out_valid_q <= 1'b1;
            out_char_q  <= kw(bus.cmd_end, 3'd0);
          end
        end
        WORD: if (bus.out_ready) begin
          idx_q      <= idx_d;
          state_q    <= last ? SEP : WORD;
          out_char_q <= last ? 8'h20 : kw(end_q, idx_d);
        end
        SEP: if (bus.out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_char_q  <= 8'h00;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready     = state_q == IDLE;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_char      = out_char_q;
  assign bus.depth         = depth_q;
  assign bus.balanced      = depth_q == '0 && !uf_q;
  assign bus.err_underflow = uf_q;
  assign bus.err_overflow  = of_q;
endmodule

// File: tb/tb_block_emitter.sv
// tb_block_emitter: vector table, hand sequences and random tokens against a queue-based keyword model
module tb_block_emitter;
  localparam int MAXD = 15;
`ifdef BLOCK_EMITTER_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  block_emitter_if #(.DEPTH_W(4)) bus();
  block_emitter #(.MAX_DEPTH(MAXD), .DEPTH_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic  e;
    string word;
    int    busy;
    int    dep;
    logic  bal;
    logic  uf;
  } vec_t;
  vec_t tbl[5];
  int checks = 0;
  int errors = 0;
  byte unsigned exp_q[$];
  int   m_depth;
  bit   m_uf, m_of;
  string got_s;
  int   n_sp;
  int   rdy_mode;
  bit   man_rdy;
  bit   prev_stall;
  logic [7:0] prev_char;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask
  task automatic chk_s(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got \"%s\" want \"%s\"", name, got, exp);
    end
  endtask
  function automatic void model_accept(input bit e);
    bit ill;
    string w;
    ill = e ? (m_depth == 0) : (m_depth == MAXD);
    if (ill) begin
      if (e) m_uf = 1'b1;
      else m_of = 1'b1;
    end else m_depth += e ? -1 : 1;
    if (!(GUARD && ill)) begin
      w = e ? "end " : "begin ";
      for (int i = 0; i < w.len(); i++) exp_q.push_back(w[i]);
    end
  endfunction
  function automatic void model_reset();
    exp_q.delete();
    m_depth = 0;
    m_uf = 1'b0;
    m_of = 1'b0;
  endfunction
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 3) != 0) : man_rdy;
    end
  end
  initial begin
    byte unsigned c;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_char", int'(bus.out_char), int'(prev_char));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_char", int'(bus.out_char), -1);
        else begin
          c = exp_q.pop_front();
          chk("char", int'(bus.out_char), int'(c));
        end
        got_s = $sformatf("%s%c", got_s, bus.out_char);
        if (bus.out_char == 8'h20) n_sp++;
      end
      if (!bus.out_valid) chk("idle_char", int'(bus.out_char), 0);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_char = bus.out_char;
      chk("depth", int'(bus.depth), m_depth);
      chk("balanced", int'(bus.balanced), int'(m_depth == 0 && !m_uf));
      chk("err_underflow", int'(bus.err_underflow), int'(m_uf));
      chk("err_overflow", int'(bus.err_overflow), int'(m_of));
    end
  end
  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b1;
  endtask
  task automatic issue(input bit e);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_end = e;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk);
        model_accept(e);
        got = 1'b1;
      end
    end
    #1;
    bus.cmd_valid = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask
  task automatic wait_idle(output int busy);
    bit done;
    done = 1'b0;
    busy = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.cmd_ready && !bus.out_valid && exp_q.size() == 0) done = 1'b1;
      else if (!bus.cmd_ready) busy++;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout got 0 want 1");
    $fatal(1, "timeout");
  end
  initial begin
    int busy, g_cnt, stalls;
    bit done;
    rdy_mode = 0;
    man_rdy = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_end = 1'b0;
    tbl[0] = '{1'b0, "begin ", 6, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, "begin ", 6, 2, 1'b0, 1'b0};
    tbl[2] = '{1'b1, "end ",   4, 1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, "end ",   4, 0, 1'b1, 1'b0};
    tbl[4] = GUARD ? '{1'b1, "", 0, 0, 1'b0, 1'b1} : '{1'b1, "end ", 4, 0, 1'b0, 1'b1};
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_char", int'(bus.out_char), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_depth", int'(bus.depth), 0);
    chk("rst_balanced", int'(bus.balanced), 1);
    chk("rst_uf", int'(bus.err_underflow), 0);
    chk("rst_of", int'(bus.err_overflow), 0);
    for (int k = 0; k < 5; k++) begin
      got_s = "";
      issue(tbl[k].e);
      wait_idle(busy);
      chk_s($sformatf("vec%0d_word", k), got_s, tbl[k].word);
      chk($sformatf("vec%0d_busy", k), busy, tbl[k].busy);
      chk($sformatf("vec%0d_depth", k), int'(bus.depth), tbl[k].dep);
      chk($sformatf("vec%0d_balanced", k), int'(bus.balanced), int'(tbl[k].bal));
      chk($sformatf("vec%0d_uf", k), int'(bus.err_underflow), int'(tbl[k].uf));
      chk($sformatf("vec%0d_cmd_ready", k), int'(bus.cmd_ready), 1);
    end
    do_reset();
    n_sp = 0;
    repeat (16) begin
      issue(1'b0);
      wait_idle(busy);
    end
    chk("ovf_depth", int'(bus.depth), 15);
    chk("ovf_flag", int'(bus.err_overflow), 1);
    chk("ovf_words", n_sp, GUARD ? 15 : 16);
    chk("ovf_uf", int'(bus.err_underflow), 0);
    do_reset();
    man_rdy = 1'b1;
    rdy_mode = 2;
    got_s = "";
    g_cnt = 0;
    stalls = 0;
    done = 1'b0;
    issue(1'b0);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_char == "e" && stalls == 0) man_rdy = 1'b0;
      if (bus.out_valid && bus.out_char == "g") begin
        g_cnt++;
        if (!bus.out_ready) begin
          stalls++;
          if (stalls == 3) man_rdy = 1'b1;
        end
      end
      if (bus.cmd_ready && !bus.out_valid) done = 1'b1;
    end
    chk("bp_done", int'(done), 1);
    chk("bp_g_cycles", g_cnt, 4);
    chk_s("bp_word", got_s, "begin ");
    rdy_mode = 0;
    do_reset();
    issue(1'b0);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.out_valid && bus.out_char == "i") done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("mid_found_i", int'(done), 1);
    reset = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", int'(bus.out_valid), 0);
    chk("mid_out_char", int'(bus.out_char), 0);
    chk("mid_cmd_ready", int'(bus.cmd_ready), 1);
    chk("mid_depth", int'(bus.depth), 0);
    chk("mid_flags", int'({bus.err_underflow, bus.err_overflow}), 0);
    got_s = "";
    issue(1'b0);
    wait_idle(busy);
    chk_s("mid_next_word", got_s, "begin ");
    do_reset();
    rdy_mode = 1;
    repeat (80) issue(1'($urandom_range(0, 1)));
    rdy_mode = 0;
    wait_idle(busy);
    chk("rand_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
